controlador_contador: RTL and testbench

Initiator-side sequencer for the counter/timer buffer. It drives that block's start and synchronous clear, runs it for a commanded number of cycles, and samples its count and timer outputs. It hands the sampled values to upstream logic with a done pulse. It sits between a command source (valid/ready) and the counter/timer buffer.

---
 rtl/controlador_contador.sv | 156 +++++++++++++++
 tb/tb_controlador_contador.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_contador.sv
// controlador_contador: initiator-side sequencer for the counter/timer buffer.
// Accepts a run length over a valid/ready handshake, clears the buffer, runs it
// for that many cycles (or until its timer saturates), samples count/timer and
// reports completion with a one-cycle done pulse.
// Optional build macro: CONTADOR_ABORT_EN adds a synchronous abort input that
// ends a run early from CLEAR or RUN.
module controlador_contador #(
    parameter int COUNT_W = 4,
    parameter int TIMER_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [TIMER_W-1:0] cmd_len,
    output logic               start,
    output logic               clr,
    input  logic [COUNT_W-1:0] count_in,
    input  logic [TIMER_W-1:0] timer_in,
`ifdef CONTADOR_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [COUNT_W-1:0] result_count,
    output logic [TIMER_W-1:0] result_timer
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SAMPLE,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] len_q, len_d;
    logic [TIMER_W-1:0] cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [COUNT_W-1:0] rcount_q, rcount_d;
    logic [TIMER_W-1:0] rtimer_q, rtimer_d;
    logic               timerFull;
    logic               lastRun;
    logic               abortHit;

    assign timerFull = (timer_in == {TIMER_W{1'b1}});
    assign lastRun   = (cnt_q == (len_q - TIMER_W'(1)));

`ifdef CONTADOR_ABORT_EN
    assign abortHit = abort;
`else
    assign abortHit = 1'b0;
`endif

    // Buffer controls and handshake status decode straight from the state register
    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign start        = (state_q == RUN);
    assign clr          = (state_q == CLEAR);
    assign done         = done_q;
    assign error        = error_q;
    assign result_count = rcount_q;
    assign result_timer = rtimer_q;

    // Next-state and registered-output logic; done/error are computed one cycle
    // ahead so they are high exactly while the FSM sits in the target cycle
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        rcount_d = rcount_q;
        rtimer_d = rtimer_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        error_d = 1'b1;
                    end else begin
                        len_d   = cmd_len;
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = RUN;
                if (abortHit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    sat_d   = 1'b0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + TIMER_W'(1);
                if (timerFull) begin
                    sat_d = 1'b1;
                end
                if (timerFull || lastRun) begin
                    state_d = SAMPLE;
                end
                if (abortHit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    sat_d   = 1'b0;
                end
            end
            SAMPLE: begin
                rcount_d = count_in;
                rtimer_d = timer_in;
                state_d  = DONE;
                done_d   = 1'b1;
                error_d  = sat_q;
            end
            DONE: begin
                sat_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            rcount_q <= '0;
            rtimer_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            done_q   <= done_d;
            error_q  <= error_d;
            rcount_q <= rcount_d;
            rtimer_q <= rtimer_d;
        end
    end

endmodule

// File: tb/tb_controlador_contador.sv
// Testbench for controlador_contador: a behavioural counter/timer buffer feeds
// the DUT; expected completions are queued when commands are issued and a
// monitor compares them whenever done or error appears.
module tb_controlador_contador;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_len;
    logic       start;
    logic       clr;
    logic [3:0] count_in;
    logic [4:0] timer_in;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] result_count;
    logic [4:0] result_timer;
`ifdef CONTADOR_ABORT_EN
    logic       abort;
`endif

    int checks;
    int failures;

    typedef struct packed {
        logic       isDone;
        logic [3:0] cnt;
        logic [4:0] tmr;
        logic       err;
    } expT;

    expT sbQ[$];
    expT monEntry;

    logic [3:0] bufCount;
    logic [4:0] bufTimer;
    logic       satMode;

    controlador_contador #(.COUNT_W(4), .TIMER_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_len      (cmd_len),
        .start        (start),
        .clr          (clr),
        .count_in     (count_in),
        .timer_in     (timer_in),
`ifdef CONTADOR_ABORT_EN
        .abort        (abort),
`endif
        .busy         (busy),
        .done         (done),
        .error        (error),
        .result_count (result_count),
        .result_timer (result_timer)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural counter/timer buffer: cleared by clr, counts while start is high
    initial begin
        bufCount = '0;
        bufTimer = '0;
    end
    always @(posedge clk) begin
        if (clr) begin
            bufCount <= '0;
            bufTimer <= '0;
        end else if (start) begin
            bufCount <= bufCount + 4'd1;
            bufTimer <= bufTimer + 5'd1;
        end
    end

    // In saturation mode the timer is forced to all-ones from the 3rd RUN cycle
    assign timer_in = (satMode && bufCount >= 4'd2) ? 5'd31 : bufTimer;
    assign count_in = bufCount;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Present one command for a single handshake edge; returns at the negedge of E+1
    task automatic applyStimulus(input logic [4:0] len, input logic doPush, input expT e);
        cmd_valid = 1'b1;
        cmd_len   = len;
        if (doPush) sbQ.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitReady(input int budget);
        int n;
        n = 0;
        while (!cmd_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_ready_timeout", {31'd0, cmd_ready}, 32'd1);
    endtask

    // Monitor: every done or error pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (reset && (done || error)) begin
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pulse: got done=%0d error=%0d expected none at %0t",
                         done, error, $time);
            end else begin
                monEntry = sbQ.pop_front();
                checkOutput("sb_done", {31'd0, done}, {31'd0, monEntry.isDone});
                checkOutput("sb_error", {31'd0, error}, {31'd0, monEntry.err});
                if (monEntry.isDone) begin
                    checkOutput("sb_result_count", {28'd0, result_count}, {28'd0, monEntry.cnt});
                    checkOutput("sb_result_timer", {27'd0, result_timer}, {27'd0, monEntry.tmr});
                end
            end
        end
    end

    // Directed test sequence
    initial begin
        int lastAccept;
        int accepts;
        checks    = 0;
        failures  = 0;
        satMode   = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        reset     = 1'b0;
`ifdef CONTADOR_ABORT_EN
        abort     = 1'b0;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_start", {31'd0, start}, 32'd0);
        checkOutput("rst_clr", {31'd0, clr}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_error", {31'd0, error}, 32'd0);
        checkOutput("rst_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rst_rcount", {28'd0, result_count}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Normal run, len=7
        applyStimulus(5'd7, 1'b1, '{isDone: 1'b1, cnt: 4'd7, tmr: 5'd7, err: 1'b0});
        checkOutput("norm_clr_E1", {31'd0, clr}, 32'd1);
        checkOutput("norm_start_E1", {31'd0, start}, 32'd0);
        checkOutput("norm_ready_E1", {31'd0, cmd_ready}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput("norm_start_run", {31'd0, start}, 32'd1);
        end
        @(negedge clk);
        checkOutput("norm_start_sample", {31'd0, start}, 32'd0);
        checkOutput("norm_busy_sample", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("norm_done_E10", {31'd0, done}, 32'd1);
        @(negedge clk);
        checkOutput("norm_ready_E11", {31'd0, cmd_ready}, 32'd1);

        // Reset mid-RUN: no pulse may follow, results return to zero
        applyStimulus(5'd7, 1'b0, '0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_start", {31'd0, start}, 32'd0);
        checkOutput("mid_rst_clr", {31'd0, clr}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_rcount", {28'd0, result_count}, 32'd0);
        checkOutput("mid_rst_rtimer", {27'd0, result_timer}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("mid_rst_idle", {31'd0, busy}, 32'd0);

        // Zero length: error pulse only, FSM stays idle
        applyStimulus(5'd0, 1'b1, '{isDone: 1'b0, cnt: 4'd0, tmr: 5'd0, err: 1'b1});
        checkOutput("zero_error", {31'd0, error}, 32'd1);
        checkOutput("zero_busy", {31'd0, busy}, 32'd0);
        checkOutput("zero_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        checkOutput("zero_error_drop", {31'd0, error}, 32'd0);
        checkOutput("zero_busy_after", {31'd0, busy}, 32'd0);

        // Back-pressure: cmd_valid held high with len=2, one accept per 6 cycles
        cmd_valid = 1'b1;
        cmd_len   = 5'd2;
        sbQ.push_back('{isDone: 1'b1, cnt: 4'd2, tmr: 5'd2, err: 1'b0});
        lastAccept = 0;
        accepts    = 1;
        for (int i = 1; i < 18; i++) begin
            @(negedge clk);
            checkOutput("bp_ready", {31'd0, cmd_ready}, {31'd0, ((i % 6) == 0)});
            if (cmd_ready) begin
                checkOutput("bp_spacing", i - lastAccept, 32'd6);
                lastAccept = i;
                accepts++;
                sbQ.push_back('{isDone: 1'b1, cnt: 4'd2, tmr: 5'd2, err: 1'b0});
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("bp_accepts", accepts, 32'd3);
        @(negedge clk);

        // Saturation: timer forced to 31 on 3rd RUN cycle
        satMode = 1'b1;
        applyStimulus(5'd31, 1'b1, '{isDone: 1'b1, cnt: 4'd3, tmr: 5'd31, err: 1'b1});
        repeat (5) @(negedge clk);
        checkOutput("sat_done", {31'd0, done}, 32'd1);
        checkOutput("sat_error", {31'd0, error}, 32'd1);
        waitReady(60);
        satMode = 1'b0;
        @(negedge clk);

`ifdef CONTADOR_ABORT_EN
        // Abort on 4th RUN cycle: results stay from the saturation run
        applyStimulus(5'd10, 1'b1, '{isDone: 1'b1, cnt: 4'd3, tmr: 5'd31, err: 1'b1});
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_done", {31'd0, done}, 32'd1);
        checkOutput("abort_error", {31'd0, error}, 32'd1);
        checkOutput("abort_start", {31'd0, start}, 32'd0);
        checkOutput("abort_rcount", {28'd0, result_count}, 32'd3);
        @(negedge clk);
        checkOutput("abort_ready", {31'd0, cmd_ready}, 32'd1);
`endif

        repeat (4) @(negedge clk);
        checkOutput("sb_empty", sbQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
